// File: rtl/regbank_pkg.sv
// ---------------------------------------------------------------------------
// regbank_pkg
//   Shared types and defaults for the two-requester register bank arbiter.
//   - DATA_W_DEF / ADDR_W_DEF : default word width and address width
//   - state_t                 : arbiter FSM states (IDLE -> GRANT -> DONE)
//   - req_idx_t               : requester index (0 or 1)
//   - rr_winner()             : round-robin pick between two requesters
// ---------------------------------------------------------------------------
package regbank_pkg;

   localparam int DATA_W_DEF = 4;
   localparam int ADDR_W_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   typedef logic req_idx_t;

   // On contention the requester that was not served last wins; a lone
   // requester always wins.
   function automatic req_idx_t rr_winner(input logic req0,
                                          input logic req1,
                                          input req_idx_t last_served);
      if (req0 && req1) begin
         return ~last_served;
      end else if (req0) begin
         return 1'b0;
      end else begin
         return 1'b1;
      end
   endfunction

endpackage

// File: rtl/reg_word.sv
// ---------------------------------------------------------------------------
// reg_word
//   One DATA_W-bit storage word with load enable and asynchronous
//   active-low clear. One instance per bank address.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low clear (word -> 0)
//     en    : load d on the next rising edge
//     d     : data to load
//     q     : stored word
// ---------------------------------------------------------------------------
module reg_word #(
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] word_q;
   logic [DATA_W-1:0] word_d;

   always_comb begin
      word_d = word_q;
      if (en) begin
         word_d = d;
      end
   end

   // NOTE: the bank is built from flops, not a RAM macro, so every word can
   // and must clear on reset; a RAM array would not be reset here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= '0;
      end else begin
         word_q <= word_d;
      end
   end

   assign q = word_q;

endmodule

// File: rtl/reg_bank_arbiter.sv
// ---------------------------------------------------------------------------
// reg_bank_arbiter
//   Two requesters share a 2**ADDR_W x DATA_W register bank. A transaction
//   takes IDLE -> GRANT -> DONE: the winner is granted for one cycle, then
//   the access commits (write, or read into rdata) with a one-cycle ack.
//   Dropping req while granted aborts the transaction silently.
//   Ports:
//     c              : clock, rising edge
//     rst_n          : asynchronous active-low reset
//     req0/req1      : transaction request, held until ack
//     wr0/wr1        : 1 = write, 0 = read
//     addr0/addr1    : target register
//     wdata0/wdata1  : write data
//     gnt0/gnt1      : registered grant, one-hot or zero
//     ack0/ack1      : registered one-cycle completion pulse
//     rdata          : read result, holds its value outside ack cycles
//   Configuration:
//     ARB_FIXED_PRIO_EN defined   -> requester 0 always wins contention
//     ARB_FIXED_PRIO_EN undefined -> round-robin on contention
// ---------------------------------------------------------------------------
module reg_bank_arbiter
   import regbank_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              c,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              wr0,
   input  logic              wr1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   state_t            state_q, state_d;
   logic              gnt0_q, gnt0_d;
   logic              gnt1_q, gnt1_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic [DATA_W-1:0] word_q [DEPTH];

   // ---------------------------------------------------------------------
   // Granted requester and its sampled operands. In GRANT exactly one gnt
   // flop is set, so gnt1_q alone identifies the owner.
   // ---------------------------------------------------------------------
   req_idx_t          owner;
   logic              owner_req;
   logic              sel_wr;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              commit;

   assign owner     = gnt1_q;
   assign owner_req = owner ? req1   : req0;
   assign sel_wr    = owner ? wr1    : wr0;
   assign sel_addr  = owner ? addr1  : addr0;
   assign sel_wdata = owner ? wdata1 : wdata0;
   assign commit    = (state_q == ST_GRANT) && owner_req;

   // ---------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------
   req_idx_t winner;

`ifdef ARB_FIXED_PRIO_EN
   assign winner = req0 ? 1'b0 : 1'b1;
`else
   // Index of the requester served by the most recent ack. Reset to 1 so
   // the first contention goes to requester 0.
   req_idx_t last_q, last_d;

   always_comb begin
      last_d = last_q;
      if (commit) begin
         last_d = owner;
      end
   end

   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

   assign winner = rr_winner(req0, req1, last_q);
`endif

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state. An abort in GRANT also returns straight to IDLE.
   // ---------------------------------------------------------------------
   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (req0 || req1) state_d = ST_GRANT;
         ST_GRANT: state_d = commit ? ST_DONE : ST_IDLE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs (next values of the registered gnt/ack/rdata)
   // ---------------------------------------------------------------------
   always_comb begin
      gnt0_d  = 1'b0;
      gnt1_d  = 1'b0;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      rdata_d = rdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req0 || req1) begin
               gnt0_d = (winner == 1'b0);
               gnt1_d = (winner == 1'b1);
            end
         end
         ST_GRANT: begin
            if (commit) begin
               ack0_d = (owner == 1'b0);
               ack1_d = (owner == 1'b1);
               if (!sel_wr) begin
                  rdata_d = word_q[sel_addr];
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         rdata_q <= rdata_d;
      end
   end

   // ---------------------------------------------------------------------
   // Register bank
   // ---------------------------------------------------------------------
   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      reg_word #(
         .DATA_W (DATA_W)
      ) u_word (
         .clk   (c),
         .rst_n (rst_n),
         .en    (commit && sel_wr && (sel_addr == ADDR_W'(i))),
         .d     (sel_wdata),
         .q     (word_q[i])
      );
   end

   assign gnt0  = gnt0_q;
   assign gnt1  = gnt1_q;
   assign ack0  = ack0_q;
   assign ack1  = ack1_q;
   assign rdata = rdata_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_bank_arbiter
//   Self-checking bench for reg_bank_arbiter. The reference model is a
//   transaction-level view: a register array, the last-served requester and
//   the last read value. Directed steps first, then randomized transactions.
// ---------------------------------------------------------------------------
module tb_reg_bank_arbiter;

   logic       c = 1'b0;
   logic       rst_n;
   logic       req0, req1, wr0, wr1;
   logic [1:0] addr0, addr1;
   logic [3:0] wdata0, wdata1;
   logic       gnt0, gnt1, ack0, ack1;
   logic [3:0] rdata;

   int tests = 0;
   int fails = 0;

   // Reference model
   logic [3:0] mem [4];
   bit         last1;      // 1 when requester 1 was served last
   logic [3:0] mdl_rdata;

   always #5 c = ~c;

   reg_bank_arbiter dut (
      .c      (c),
      .rst_n  (rst_n),
      .req0   (req0),
      .req1   (req1),
      .wr0    (wr0),
      .wr1    (wr1),
      .addr0  (addr0),
      .addr1  (addr1),
      .wdata0 (wdata0),
      .wdata1 (wdata1),
      .gnt0   (gnt0),
      .gnt1   (gnt1),
      .ack0   (ack0),
      .ack1   (ack1),
      .rdata  (rdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge c);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) mem[i] = 4'h0;
      last1     = 1'b1;
      mdl_rdata = 4'h0;
   endtask

   function automatic int pick(input bit r0, input bit r1);
      if (r0 && r1) begin
`ifdef ARB_FIXED_PRIO_EN
         return 0;
`else
         return last1 ? 0 : 1;
`endif
      end
      return r0 ? 0 : 1;
   endfunction

   task automatic check_quiet(input string tag);
      check({tag, "_gnt0"}, gnt0, 1'b0);
      check({tag, "_gnt1"}, gnt1, 1'b0);
      check({tag, "_ack0"}, ack0, 1'b0);
      check({tag, "_ack1"}, ack1, 1'b0);
      check({tag, "_rdata"}, rdata, mdl_rdata);
   endtask

   // One full transaction starting with the DUT idle. clr drops both reqs
   // after the ack; do_done steps through the DONE cycle.
   task automatic run_txn(input string tag, input bit r0, input bit r1,
                          input bit w0, input logic [1:0] a0, input logic [3:0] d0,
                          input bit w1, input logic [1:0] a1, input logic [3:0] d1,
                          input bit clr, input bit do_done);
      int         win;
      bit         w;
      logic [1:0] a;
      logic [3:0] d;
      req0 = r0; wr0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; wr1 = w1; addr1 = a1; wdata1 = d1;
      win = pick(r0, r1);
      w   = (win == 0) ? w0 : w1;
      a   = (win == 0) ? a0 : a1;
      d   = (win == 0) ? d0 : d1;
      tick();
      check({tag, "_g_gnt0"}, gnt0, win == 0);
      check({tag, "_g_gnt1"}, gnt1, win == 1);
      check({tag, "_g_ack"}, {ack1, ack0}, 2'b00);
      tick();
      check({tag, "_a_gnt"}, {gnt1, gnt0}, 2'b00);
      check({tag, "_a_ack0"}, ack0, win == 0);
      check({tag, "_a_ack1"}, ack1, win == 1);
      if (!w) mdl_rdata = mem[a];
      else    mem[a] = d;
      check({tag, "_a_rdata"}, rdata, mdl_rdata);
      last1 = (win == 1);
      if (clr) begin
         req0 = 1'b0;
         req1 = 1'b0;
      end
      if (do_done) begin
         tick();
         check_quiet({tag, "_done"});
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      model_reset();
      #12;
      check_quiet("reset");
      @(negedge c);
      rst_n = 1'b1;
      tick();
      check_quiet("post_reset");

      // Write 4'hA to address 2, then read it back through requester 1
      run_txn("w028", 1, 0, 1, 2'd2, 4'hA, 0, 2'd0, 4'h0, 1, 1);
      run_txn("r029", 0, 1, 0, 2'd0, 4'h0, 0, 2'd2, 4'h0, 1, 1);
      check("r029_value", rdata, 4'hA);

      // Contention twice with both requests held through DONE
      run_txn("c030a", 1, 1, 0, 2'd1, 4'h0, 0, 2'd2, 4'h0, 0, 1);
      run_txn("c030b", 1, 1, 0, 2'd1, 4'h0, 0, 2'd2, 4'h0, 1, 1);

      // Abort: req0 dropped while granted
      req0 = 1; wr0 = 1; addr0 = 2'd0; wdata0 = 4'hF;
      tick();
      check("abort_gnt0", gnt0, 1'b1);
      req0 = 1'b0;
      tick();
      check_quiet("abort");
      // Idle again right away: requester 1 is granted on the very next edge
      run_txn("abort_rd", 0, 1, 0, 2'd0, 4'h0, 0, 2'd0, 4'h0, 1, 1);

      // Later write to the same address wins
      run_txn("w033a", 1, 0, 1, 2'd1, 4'h3, 0, 2'd0, 4'h0, 1, 1);
      run_txn("w033b", 0, 1, 0, 2'd0, 4'h0, 1, 2'd1, 4'hC, 1, 1);
      run_txn("r033",  1, 0, 0, 2'd1, 4'h0, 0, 2'd0, 4'h0, 1, 1);
      check("r033_value", rdata, 4'hC);

      // Reset asserted while in DONE after committing 4'h5
      run_txn("w032", 1, 0, 1, 2'd3, 4'h5, 0, 2'd0, 4'h0, 1, 0);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_quiet("rst_done");
      tick();
      @(negedge c);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_quiet($sformatf("after_rst%0d", i));
      end
      for (int i = 0; i < 4; i++) begin
         run_txn($sformatf("clr_rd%0d", i), 1, 0, 0, 2'(i), 4'h0, 0, 2'd0, 4'h0, 1, 1);
      end

      // Randomized transactions
      for (int n = 0; n < 60; n++) begin
         bit r0, r1;
         r0 = 1'($urandom_range(0, 1));
         r1 = 1'($urandom_range(0, 1));
         if (!r0 && !r1) r0 = 1'b1;
         run_txn($sformatf("rnd%0d", n), r0, r1,
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
